acc_muldiv_ctrl: RTL
====================

ACC_MULDIV_CTRL -- requirements
Module: acc_muldiv_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port reset_p  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port start  in  1  one-cycle request; sampled only in IDLE.
REQ-004 SHALL have port op  in  1  0 = multiply, 1 = divide; sampled with start.
REQ-005 SHALL have port operand_b  in  4  multiplicand / divisor, ALU B operand; held stable while busy.
REQ-006 SHALL have port acc_high_data2alu  in  4  accumulator high half.
REQ-007 SHALL have port acc_low_data2alu  in  4  accumulator low half.
REQ-008 SHALL have port alu_carry  in  1  add: carry-out; sub: 1 = no borrow.
REQ-009 SHALL have outputs: alu_op_sub  1  ALU add(0)/sub(1); acc_high_reset_p  1; fill_value  1; acc_in_select  1 (0 = ALU); acc_high_select  2; acc_low_select  2.
REQ-010 SHALL have outputs busy  1, done  1 (one-cycle pulse), div_err  1 (valid with done).

Function
REQ-011 SHALL use half-select encoding 00 hold, 01 shift right, 10 shift left, 11 load.
REQ-012 Precondition: acc low holds operand A at start; acc high contents don't care.
REQ-013 SHALL implement states IDLE, CLEAR, M_ADD, M_SHIFT, D_SHIFT, D_SUB, D_FIX, DONE; 2-bit iteration counter.
REQ-014 IDLE + start + (op=0 or operand_b!=0) -> CLEAR; op=1 with operand_b=0 -> DONE with div_err=1, accumulator untouched.
REQ-015 CLEAR: acc_high_reset_p=1 one cycle, counter=0, carry_q=0, q_pend=0; -> M_ADD (op=0) or D_SHIFT (op=1).
REQ-016 M_ADD: alu_op_sub=0; if acc_low_data2alu[0]=1: high select 11, acc_in_select=0, carry_q<=alu_carry; else high 00, carry_q<=0; -> M_SHIFT.
REQ-017 M_SHIFT: both selects 01, fill_value=carry_q; counter+1; counter=3 -> DONE else -> M_ADD.
REQ-018 Multiply result: {high,low} = A*B, 8 bits unsigned.
REQ-019 D_SHIFT: both selects 10, fill_value=q_pend; -> D_SUB.
REQ-020 D_SUB: alu_op_sub=1; if alu_carry=1: high select 11 from ALU, q_pend<=1; else high 00, q_pend<=0; counter+1; counter=3 -> D_FIX else -> D_SHIFT.
REQ-021 D_FIX: low select 10, high 00, fill_value=q_pend; -> DONE.
REQ-022 Divide result: low = A/B quotient, high = A mod B.
REQ-023 DONE: done=1, div_err per REQ-014 else 0; -> IDLE next cycle.
REQ-024 busy=1 in every state except IDLE; start while busy SHALL be ignored.
REQ-025 Latency: start accepted edge k; done high cycle k+10 multiply, k+11 divide, k+1 divide-by-zero.
REQ-026 In states not listed as driving a control, it SHALL be 0 (selects 00, hold).
REQ-027 Control outputs SHALL be combinational decode of state and registered inputs only; no combinational start-to-select path.

Reset
REQ-028 reset_p SHALL force IDLE, counter=0, carry_q=0, q_pend=0 on the next edge, including mid-operation.
REQ-029 After reset all outputs SHALL be 0; accumulator contents after mid-operation reset are undefined.

Structure
REQ-030 Shared package SHALL hold state encoding, select encodings (hold/shift right/shift left/load) and op codes.
REQ-031 No sub-module; counter and state machine inline. Bench instantiates acc, ALU and this block together.

Verification
REQ-032 A=13 low, B=11, op=0 -> done at k+10, high=0x8, low=0xF, div_err=0.
REQ-033 A=15, B=15, op=0 -> high=0xE, low=0x1 (carry path exercised).
REQ-034 A=13, B=3, op=1 -> done at k+11, low=4, high=1.
REQ-035 A=7, B=0, op=1 -> done at k+1, div_err=1, acc unchanged (7).
REQ-036 reset_p asserted in M_SHIFT of multiply -> next cycle IDLE, busy=0, all selects 00; new start runs normally.
REQ-037 start pulsed during busy -> ignored; single done pulse; result matches first request.

Source files
------------

// File: rtl/acc_muldiv_ctrl_pkg.sv
// Shared encodings for the accumulator multiply/divide sequencer:
// FSM states, accumulator half-select codes and operation codes.
package acc_muldiv_ctrl_pkg;

    localparam int DATA_W = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        M_ADD   = 3'd2,
        M_SHIFT = 3'd3,
        D_SHIFT = 3'd4,
        D_SUB   = 3'd5,
        D_FIX   = 3'd6,
        DONE    = 3'd7
    } state_t;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/acc_muldiv_ctrl.sv
// Sequencer that drives an external accumulator (high/low halves) and ALU
// through 4-bit shift-add multiply and restoring divide.
module acc_muldiv_ctrl
    import acc_muldiv_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset_p,
    input  logic              start,
    input  logic              op,
    input  logic [DATA_W-1:0] operand_b,
    input  logic [DATA_W-1:0] acc_high_data2alu,
    input  logic [DATA_W-1:0] acc_low_data2alu,
    input  logic              alu_carry,
    output logic              alu_op_sub,
    output logic              acc_high_reset_p,
    output logic              fill_value,
    output logic              acc_in_select,
    output logic [1:0]        acc_high_select,
    output logic [1:0]        acc_low_select,
    output logic              busy,
    output logic              done,
    output logic              div_err,
    output logic [2:0]        state_dbg
);

    // Handshake: start is a one-cycle request taken only in IDLE (ignored while
    // busy); done pulses for exactly one cycle with div_err valid alongside it.

    state_t     state, state_n;
    logic [1:0] cnt;
    logic       carry_q;
    logic       q_pend;
    logic       op_q;
    logic       err_q;

    // The high half and upper low bits are consumed by the ALU, not here.
    logic unused_inputs;
    assign unused_inputs = ^{acc_high_data2alu, acc_low_data2alu[DATA_W-1:1]};

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            carry_q <= 1'b0;
            q_pend  <= 1'b0;
            op_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        err_q <= (op == OP_DIV) && (operand_b == '0);
                    end
                end
                CLEAR: begin
                    cnt     <= 2'd0;
                    carry_q <= 1'b0;
                    q_pend  <= 1'b0;
                end
                M_ADD:   carry_q <= acc_low_data2alu[0] & alu_carry;
                M_SHIFT: cnt <= cnt + 2'd1;
                D_SUB: begin
                    q_pend <= alu_carry;
                    cnt    <= cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n          = state;
        alu_op_sub       = 1'b0;
        acc_high_reset_p = 1'b0;
        fill_value       = 1'b0;
        acc_in_select    = 1'b0;
        acc_high_select  = SEL_HOLD;
        acc_low_select   = SEL_HOLD;
        busy             = 1'b1;
        done             = 1'b0;
        div_err          = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_n = ((op == OP_DIV) && (operand_b == '0)) ? DONE : CLEAR;
                end
            end
            CLEAR: begin
                acc_high_reset_p = 1'b1;
                state_n          = (op_q == OP_DIV) ? D_SHIFT : M_ADD;
            end
            M_ADD: begin
                if (acc_low_data2alu[0]) begin
                    acc_high_select = SEL_LOAD;
                end
                state_n = M_SHIFT;
            end
            M_SHIFT: begin
                // carry_q becomes the new MSB so the 5-bit partial sum survives the shift
                acc_high_select = SEL_SHR;
                acc_low_select  = SEL_SHR;
                fill_value      = carry_q;
                state_n         = (cnt == 2'd3) ? DONE : M_ADD;
            end
            D_SHIFT: begin
                acc_high_select = SEL_SHL;
                acc_low_select  = SEL_SHL;
                fill_value      = q_pend;
                state_n         = D_SUB;
            end
            D_SUB: begin
                alu_op_sub = 1'b1;
                if (alu_carry) begin
                    acc_high_select = SEL_LOAD;
                end
                state_n = (cnt == 2'd3) ? D_FIX : D_SHIFT;
            end
            D_FIX: begin
                // last quotient bit enters low; the bit from the first shift falls out
                acc_low_select = SEL_SHL;
                fill_value     = q_pend;
                state_n        = DONE;
            end
            DONE: begin
                done    = 1'b1;
                div_err = err_q;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
